// File: rtl/flipflop_pipe_pkg.sv
// Shared constants and width helpers for the flipflop pipeline slice.
// Stage records are {valid, data}; modules declare that struct locally from their WIDTH.
package flipflop_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Index width that never collapses to zero bits, so a single-stage pipe still has a tap select.
    function automatic int clog2_min1(input int n);
        int c;
        c = $clog2(n);
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/flipflop_pipe_if.sv
// Handshake/data bundle between a producer/consumer and the flipflop pipeline.
// The master drives data and control; the slave (the pipe) returns outputs and the tap.
interface flipflop_pipe_if
    import flipflop_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = count_width(DEPTH);
    localparam int TW = clog2_min1(DEPTH);

    logic             en;
    logic             clear;
    logic             qin_valid;
    logic [WIDTH-1:0] qin;
    logic [WIDTH-1:0] qout;
    logic             qout_valid;
    logic [CW-1:0]    occupancy;
    logic [TW-1:0]    tap_sel;
    logic [WIDTH-1:0] tap_data;
    logic             tap_valid;

    modport master (
        output en, clear, qin_valid, qin, tap_sel,
        input  qout, qout_valid, occupancy, tap_data, tap_valid
    );

    modport slave (
        input  en, clear, qin_valid, qin, tap_sel,
        output qout, qout_valid, occupancy, tap_data, tap_valid
    );

endinterface

// File: rtl/flipflop_pipe_stage.sv
// One {valid, data} register of the pipeline: async reset, synchronous clear, enable.
module flipflop_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t stage_q;

    // Clear wins over enable so a flush discards whatever is presented on the input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q.valid <= 1'b0;
            stage_q.data  <= RESET_VAL;
        end else if (clear) begin
            stage_q.valid <= 1'b0;
            stage_q.data  <= RESET_VAL;
        end else if (en) begin
            stage_q.valid <= d_valid;
            stage_q.data  <= d_data;
        end
    end

    assign q_valid = stage_q.valid;
    assign q_data  = stage_q.data;

endmodule

// File: rtl/flipflop_pipe.sv
// Stallable, flushable register pipeline of DEPTH stages with occupancy count and tap mux.
// Stages live in flipflop_stage; the top owns the occupancy counter and the tap selection.
module flipflop_pipe
    import flipflop_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic            clk,
    input logic            reset,
    flipflop_pipe_if.slave bus
);

    localparam int CW = count_width(DEPTH);

    // Index 0 is the pipe input; index k+1 is the output of stage k.
    logic [WIDTH-1:0] stage_data  [DEPTH+1];
    logic             stage_valid [DEPTH+1];
    logic [CW-1:0]    occupancy;
    logic [WIDTH-1:0] tap_data;
    logic             tap_valid;

    assign stage_data[0]  = bus.qin;
    assign stage_valid[0] = bus.qin_valid;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        flipflop_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .clear   (bus.clear),
            .en      (bus.en),
            .d_valid (stage_valid[k]),
            .d_data  (stage_data[k]),
            .q_valid (stage_valid[k+1]),
            .q_data  (stage_data[k+1])
        );
    end

    // Counted incrementally rather than popcounted; in and out on the same edge cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy <= '0;
        end else if (bus.clear) begin
            occupancy <= '0;
        end else if (bus.en) begin
            occupancy <= occupancy + CW'(bus.qin_valid) - CW'(stage_valid[DEPTH]);
        end
    end

    // Out-of-range selects fall through to the reset value with valid low.
    always_comb begin
        tap_data  = RESET_VAL;
        tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(bus.tap_sel) == i) begin
                tap_data  = stage_data[i+1];
                tap_valid = stage_valid[i+1];
            end
        end
    end

    assign bus.qout       = stage_data[DEPTH];
    assign bus.qout_valid = stage_valid[DEPTH];
    assign bus.occupancy  = occupancy;
    assign bus.tap_data   = tap_data;
    assign bus.tap_valid  = tap_valid;

endmodule

// File: tb/tb_flipflop_pipe.sv
// Self-checking bench: queue-based model for the default pipe plus directed checks on
// a single-bit single-stage pipe and a wide deep pipe with a non-zero reset value.
module tb_flipflop_pipe;
    import flipflop_pkg::*;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    flipflop_pipe_if #(.WIDTH(8),  .DEPTH(4)) ifA ();
    flipflop_pipe_if #(.WIDTH(1),  .DEPTH(1)) ifB ();
    flipflop_pipe_if #(.WIDTH(32), .DEPTH(8)) ifC ();

    flipflop_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dutA (
        .clk(clk), .reset(reset), .bus(ifA)
    );
    flipflop_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) dutB (
        .clk(clk), .reset(reset), .bus(ifB)
    );
    flipflop_pipe #(.WIDTH(32), .DEPTH(8), .RESET_VAL(32'hDEADBEEF)) dutC (
        .clk(clk), .reset(reset), .bus(ifC)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model of the default pipe: history of accepted words, newest first, trimmed to DEPTH.
    logic [8:0] hist[$];

    always @(posedge clk or posedge reset) begin
        if (reset || ifA.clear) begin
            hist.delete();
        end else if (ifA.en) begin
            hist.push_front({ifA.qin_valid, ifA.qin});
            if (hist.size() > 4) void'(hist.pop_back());
        end
    end

    function automatic logic [8:0] modelStage(input int k);
        if (k < hist.size()) return hist[k];
        return 9'h000;
    endfunction

    function automatic int modelOcc();
        int n = 0;
        foreach (hist[i]) n += int'(hist[i][8]);
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput();
        logic [8:0] last;
        logic [8:0] tap;
        last = modelStage(3);
        tap  = modelStage(int'(ifA.tap_sel));
        check("A.occupancy",  32'(ifA.occupancy),  32'(modelOcc()));
        check("A.qout_valid", 32'(ifA.qout_valid), 32'(last[8]));
        if (last[8]) check("A.qout", 32'(ifA.qout), 32'(last[7:0]));
        check("A.tap_valid",  32'(ifA.tap_valid),  32'(tap[8]));
        if (tap[8]) check("A.tap_data", 32'(ifA.tap_data), 32'(tap[7:0]));
    endtask

    always @(posedge clk) begin
        #2;
        checkOutput();
    end

    task automatic applyStimulus(input logic e, input logic c, input logic v,
                                 input logic [7:0] d, input logic [1:0] sel);
        ifA.en = e; ifA.clear = c; ifA.qin_valid = v; ifA.qin = d; ifA.tap_sel = sel;
        @(posedge clk);
        #3;
    endtask

    task automatic applyStimulusB(input logic e, input logic c, input logic v,
                                  input logic d, input logic sel);
        ifB.en = e; ifB.clear = c; ifB.qin_valid = v; ifB.qin = d; ifB.tap_sel = sel;
        @(posedge clk);
        #3;
    endtask

    task automatic applyStimulusC(input logic e, input logic c, input logic v,
                                  input logic [31:0] d, input logic [2:0] sel);
        ifC.en = e; ifC.clear = c; ifC.qin_valid = v; ifC.qin = d; ifC.tap_sel = sel;
        @(posedge clk);
        #3;
    endtask

    int   expOcc [11] = '{1, 2, 3, 4, 4, 4, 4, 3, 2, 1, 0};
    int   expBub [8]  = '{1, 1, 2, 2, 2, 2, 2, 2};
    logic bV [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic bD [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        reset = 1'b1;
        ifA.en = 0; ifA.clear = 0; ifA.qin_valid = 0; ifA.qin = '0; ifA.tap_sel = '0;
        ifB.en = 0; ifB.clear = 0; ifB.qin_valid = 0; ifB.qin = '0; ifB.tap_sel = '0;
        ifC.en = 0; ifC.clear = 0; ifC.qin_valid = 0; ifC.qin = '0; ifC.tap_sel = '0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;

        check("A.reset_qout",       32'(ifA.qout),       32'h00);
        check("A.reset_qout_valid", 32'(ifA.qout_valid), 32'd0);
        check("A.reset_occupancy",  32'(ifA.occupancy),  32'd0);
        check("C.reset_qout",       ifC.qout,            32'hDEADBEEF);
        check("B.reset_tap_valid",  32'(ifB.tap_valid),  32'd0);

        // Streaming 1..7 then drain
        for (int e = 1; e <= 11; e++) begin
            if (e <= 7) applyStimulus(1, 0, 1, 8'(e), 2'd0);
            else        applyStimulus(1, 0, 0, 8'h00, 2'd0);
            check("A.stream_occ", 32'(ifA.occupancy), 32'(expOcc[e-1]));
            check("A.stream_qout_valid", 32'(ifA.qout_valid), 32'((e >= 4 && e <= 10) ? 1 : 0));
            if (e >= 4 && e <= 10) check("A.stream_qout", 32'(ifA.qout), 32'(e - 3));
        end

        // Stall with three words inside
        for (int k = 1; k <= 3; k++) applyStimulus(1, 0, 1, 8'(8'h30 + k), 2'd2);
        check("A.stall_pre_occ", 32'(ifA.occupancy), 32'd3);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 1, 8'hFF, 2'd2);
            check("A.stall_occ",        32'(ifA.occupancy),  32'd3);
            check("A.stall_tap_data",   32'(ifA.tap_data),   32'h31);
            check("A.stall_qout_valid", 32'(ifA.qout_valid), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 0, 8'h00, 2'd2);
            check("A.resume_occ", 32'(ifA.occupancy), 32'(3 - k));
            check("A.resume_qout_valid", 32'(ifA.qout_valid), 32'((k < 3) ? 1 : 0));
            if (k < 3) check("A.resume_qout", 32'(ifA.qout), 32'(8'h31 + k));
        end

        // Flush priority over enable and a valid input
        for (int k = 1; k <= 4; k++) applyStimulus(1, 0, 1, 8'(8'h40 + k), 2'd0);
        check("A.flush_pre_occ", 32'(ifA.occupancy), 32'd4);
        applyStimulus(1, 1, 1, 8'hAA, 2'd0);
        check("A.flush_occ",        32'(ifA.occupancy),  32'd0);
        check("A.flush_qout_valid", 32'(ifA.qout_valid), 32'd0);
        for (int s = 0; s < 4; s++) begin
            ifA.tap_sel = 2'(s);
            #1;
            check("A.flush_tap_valid", 32'(ifA.tap_valid), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 0, 8'h00, 2'd3);
            check("A.flush_aa_absent", 32'(ifA.qout_valid), 32'd0);
        end

        // Bubbles with tap on stage 2
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1, 0, k[0], 8'(8'h11 * k), 2'd2);
            check("A.bubble_occ", 32'(ifA.occupancy), 32'(expBub[k-1]));
            if (k == 5) begin
                check("A.bubble_tap_data",  32'(ifA.tap_data),  32'h33);
                check("A.bubble_tap_valid", 32'(ifA.tap_valid), 32'd1);
            end
            if (k == 6) check("A.bubble_tap_gap", 32'(ifA.tap_valid), 32'd0);
        end
        for (int k = 0; k < 5; k++) applyStimulus(1, 0, 0, 8'h00, 2'd3);
        ifA.en = 1'b0;

        // Single-bit, single-stage corner
        for (int i = 0; i < 5; i++) begin
            applyStimulusB(1, 0, bV[i], bD[i], 1'b0);
            check("B.occ",        32'(ifB.occupancy),  32'(bV[i]));
            check("B.qout_valid", 32'(ifB.qout_valid), 32'(bV[i]));
            check("B.tap_valid",  32'(ifB.tap_valid),  32'(bV[i]));
            if (bV[i]) check("B.qout", 32'(ifB.qout), 32'(bD[i]));
        end
        applyStimulusB(1, 0, 1, 1'b1, 1'b1);
        check("B.oor_qout_valid", 32'(ifB.qout_valid), 32'd1);
        check("B.oor_tap_valid",  32'(ifB.tap_valid),  32'd0);
        check("B.oor_tap_data",   32'(ifB.tap_data),   32'd0);
        ifB.en = 1'b0;

        // Wide, deep pipe with non-zero reset value
        applyStimulusC(1, 0, 1, 32'h12345678, 3'd0);
        for (int k = 2; k <= 8; k++) begin
            applyStimulusC(1, 0, 0, 32'h0, 3'd0);
            check("C.latency_valid", 32'(ifC.qout_valid), 32'((k == 8) ? 1 : 0));
        end
        check("C.qout", ifC.qout, 32'h12345678);
        check("C.occ",  32'(ifC.occupancy), 32'd1);
        applyStimulusC(0, 1, 0, 32'h0, 3'd0);
        check("C.clear_qout",       ifC.qout,             32'hDEADBEEF);
        check("C.clear_qout_valid", 32'(ifC.qout_valid),  32'd0);
        check("C.clear_occ",        32'(ifC.occupancy),   32'd0);
        ifC.clear = 1'b0;

        // Asynchronous reset mid-cycle with the pipe full
        for (int k = 1; k <= 4; k++) applyStimulus(1, 0, 1, 8'(8'h60 + k), 2'd0);
        ifA.en = 1'b0;
        check("A.full_before_reset", 32'(ifA.occupancy), 32'd4);
        #2;
        reset = 1'b1;
        #1;
        check("A.async_qout",       32'(ifA.qout),       32'h00);
        check("A.async_qout_valid", 32'(ifA.qout_valid), 32'd0);
        check("A.async_occ",        32'(ifA.occupancy),  32'd0);
        check("A.async_tap_valid",  32'(ifA.tap_valid),  32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        applyStimulus(1, 0, 1, 8'h5A, 2'd0);
        check("A.post_reset_tap",   32'(ifA.tap_data),  32'h5A);
        check("A.post_reset_valid", 32'(ifA.tap_valid), 32'd1);
        check("A.post_reset_occ",   32'(ifA.occupancy), 32'd1);
        applyStimulus(0, 0, 0, 8'h00, 2'd0);

        repeat (2) @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flipflop_pipe.md
Name: flipflop_pipe

Overview:
Parametrised, stallable register pipeline. It is the successor to the single 8-bit flipflop: configurable data width and stage count, with per-stage valid tracking, a global enable (stall), a synchronous flush, a registered occupancy count and a selectable tap. It sits between producer and consumer datapaths wherever a fixed-latency, stallable delay line is needed.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 4, number of register stages (>=1); this is the latency in enabled cycles
RESET_VAL, '0, WIDTH-bit value loaded into every data stage on reset or flush

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  shift enable; 0 = stall (all state holds)
clear  input  1  synchronous flush; takes priority over en
qin_valid  input  1  qin carries valid data
qin  input  WIDTH  input data
qout  output  WIDTH  data of the last stage (stage DEPTH-1)
qout_valid  output  1  valid bit of the last stage
occupancy  output  CW=$clog2(DEPTH+1)  number of stages currently holding valid data
tap_sel  input  TW=max(1,$clog2(DEPTH))  stage index selected for tap outputs
tap_data  output  WIDTH  data of stage tap_sel (combinational mux of registers)
tap_valid  output  1  valid bit of stage tap_sel; 0 if tap_sel>=DEPTH

Behaviour:
- Reset (async, while reset=1): every stage data=RESET_VAL, every valid=0, occupancy=0. So qout=RESET_VAL, qout_valid=0, and tap_valid=0.
- Priority at each posedge: reset > clear > en > hold.
- clear=1: same end state as reset, but synchronous. qin is discarded even if en=1 and qin_valid=1.
- en=1, clear=0:
  - stage0 <= {qin_valid, qin}
  - stage k <= stage k-1 for k=1..DEPTH-1
  - The last stage's previous contents leave the pipe.
- en=0, clear=0: all data, valid and occupancy hold. qin is ignored.
- Data is shifted regardless of its valid bit. Invalid slots carry whatever qin held, so only the valid bits are meaningful for checking.
- Latency: a word accepted at enabled edge N appears on qout after exactly DEPTH enabled edges. Stalled cycles do not count.
- occupancy is a registered counter, not a popcount. On an enabled edge it updates as occupancy + qin_valid - last_stage_valid.
  - Simultaneous in and out leaves it unchanged.
  - It never exceeds DEPTH and never underflows.
  - Invariant: occupancy equals the popcount of the valid bits. The verifier checks this every cycle.
- DEPTH=1: TW=1 and tap_sel=0 selects the single stage; tap_sel=1 gives tap_valid=0 and tap_data=RESET_VAL.
- Any out-of-range tap_sel gives tap_data=RESET_VAL and tap_valid=0.
- Reset asserted mid-stream clears immediately, without waiting for a clock edge. After reset deasserts, the first enabled edge loads stage0 normally.
- No X propagation: all registers have a defined reset value.

Decomposition:
- Package flipflop_pkg holds:
  - typedef struct packed {logic valid; logic [WIDTH-1:0] data;} form, realised as a parametrised helper (the package offers the width function clog2_min1(n) = max(1,$clog2(n)))
  - shared default constants DEF_WIDTH=8 and DEF_DEPTH=4
- Sub-module flipflop_stage: one WIDTH+1-bit register with async reset, sync clear and enable. It is instantiated DEPTH times in a generate loop.
- The top level owns the occupancy counter and the tap mux.

Test Plan:
- Reset check: assert reset mid-cycle with the pipe full -> qout=8'h00, qout_valid=0, occupancy=0 before the next posedge.
- Streaming (WIDTH=8, DEPTH=4, en=1): qin=1..7 with valid, one per cycle -> qout=1 on the 4th edge after it was driven, then 2..7 on consecutive cycles. occupancy ramps 1,2,3,4, holds at 4, then drains 3,2,1,0.
- Stall: load 3 words, hold en=0 for 5 cycles -> qout, tap_data and occupancy=3 unchanged; resuming en=1 completes each word's remaining latency exactly.
- Flush priority: with occupancy=4, drive clear=1, en=1, qin_valid=1, qin=8'hAA -> next cycle occupancy=0, all tap_valid=0, 8'hAA not captured.
- Bubbles and tap: alternate qin_valid 1/0 with qin=8'h11,8'h22,... -> occupancy alternates correctly; tap_sel=2 shows the word injected 3 enabled edges earlier; tap_sel=3 matches qout.
- Parameter corners: DEPTH=1, WIDTH=1 -> 1-cycle latency, occupancy toggles 0/1, and tap_sel=1 gives tap_valid=0. Also WIDTH=32, DEPTH=8 with RESET_VAL=32'hDEADBEEF -> qout=32'hDEADBEEF after reset and after clear.
